// File: rtl/rv_lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_lsu_pkg : funct3 access encodings and LSU state type
// Rev 1.0
// ----------------------------------------------------------------------------
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // log2 of the access size in bytes
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_lsu_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_lsu_if : MEM-stage request and data-memory bus of the load/store unit
// Rev 1.0
// ----------------------------------------------------------------------------
interface rv_lsu_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            MemRead;
  logic            MemWrite;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            stall;
  logic [XLEN-1:0] rdata;
  logic            misaligned;
  logic            timeout;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [NB-1:0]   mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  MemRead, MemWrite, funct3, addr, wdata, mem_ready, mem_rdata,
    output stall, rdata, misaligned, timeout,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output MemRead, MemWrite, funct3, addr, wdata, mem_ready, mem_rdata,
    input  stall, rdata, misaligned, timeout,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/rv_lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_lsu_align : alignment check, store lane steering, load extraction/extension
// Rev 1.0
// ----------------------------------------------------------------------------
module rv_lsu_align
  import rv_lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OB   = $clog2(NB)
) (
  input  logic [2:0]      req_f3_i,
  input  logic [OB-1:0]   req_off_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            aligned_o,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [2:0]      ld_f3_i,
  input  logic [OB-1:0]   ld_off_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  localparam bit IS64 = (XLEN == 64);

  logic [1:0]      size;
  logic [3:0]      size_mask;
  logic            legal;
  logic [XLEN-1:0] ld_shifted;

  always_comb begin
    size      = f3_size(req_f3_i);
    size_mask = 4'b0000;
    be_o      = '0;
    case (size)
      2'd0: begin size_mask = 4'b0000; be_o = NB'(1)  << req_off_i; end
      2'd1: begin size_mask = 4'b0001; be_o = NB'(3)  << req_off_i; end
      2'd2: begin size_mask = 4'b0011; be_o = NB'(15) << req_off_i; end
      default: begin size_mask = 4'b0111; be_o = '1; end
    endcase
    // Doubleword and WU only exist on RV64; 111 is not a load/store encoding
    legal     = (req_f3_i != 3'b111) && (IS64 || ((size != 2'd3) && (req_f3_i != F3_WU)));
    aligned_o = legal && ((4'(req_off_i) & size_mask) == 4'b0000);
  end

  assign wdata_o = req_wdata_i << {req_off_i, 3'b000};

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_f3_i)
      F3_B:    ld_data_o = XLEN'($signed(ld_shifted[7:0]));
      F3_BU:   ld_data_o = XLEN'(ld_shifted[7:0]);
      F3_H:    ld_data_o = XLEN'($signed(ld_shifted[15:0]));
      F3_HU:   ld_data_o = XLEN'(ld_shifted[15:0]);
      F3_W:    ld_data_o = XLEN'($signed(ld_shifted[31:0]));
      F3_WU:   ld_data_o = XLEN'(ld_shifted[31:0]);
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_lsu : load/store unit with handshake, byte lanes, extension and timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic     CLK,
  input  logic     RESET_N,
  rv_lsu_if.slave  bus
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);

  lsu_state_t      state_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [NB-1:0]   mem_be_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [2:0]      f3_q;
  logic [OB-1:0]   off_q;

  logic            req;
  logic            aligned;
  logic            last_wait;
  logic [NB-1:0]   be_w;
  logic [XLEN-1:0] wdata_w;
  logic [XLEN-1:0] ld_data_w;

  rv_lsu_align #(.XLEN(XLEN)) u_align (
    .req_f3_i    (bus.funct3),
    .req_off_i   (bus.addr[OB-1:0]),
    .req_wdata_i (bus.wdata),
    .aligned_o   (aligned),
    .be_o        (be_w),
    .wdata_o     (wdata_w),
    .ld_f3_i     (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (bus.mem_rdata),
    .ld_data_o   (ld_data_w)
  );

  assign req       = bus.MemRead | bus.MemWrite;
  assign last_wait = (cnt_q == CW'(MAX_WAIT - 1));

  assign bus.stall      = ((state_q == IDLE) && req && aligned) || (state_q == WAIT);
  assign bus.misaligned = (state_q == IDLE) && req && !aligned;
  // A same-cycle mem_ready takes priority over the timeout
  assign bus.timeout    = (state_q == WAIT) && !bus.mem_ready && last_wait;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && aligned) begin
            state_q     <= WAIT;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.MemWrite;
            mem_addr_q  <= {bus.addr[XLEN-1:OB], {OB{1'b0}}};
            mem_be_q    <= be_w;
            mem_wdata_q <= wdata_w;
            f3_q        <= bus.funct3;
            off_q       <= bus.addr[OB-1:0];
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            if (!mem_we_q) begin
              rdata_q <= ld_data_w;
            end
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end else if (last_wait) begin
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rv_lsu : scoreboard bench for rv_lsu at XLEN=32 (MAX_WAIT=3) and XLEN=64
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rv_lsu;
  import rv_lsu_pkg::*;

  localparam int MW32 = 3;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  rv_lsu_if #(.XLEN(32)) bus32 ();
  rv_lsu_if #(.XLEN(64)) bus64 ();

  rv_lsu #(.XLEN(32), .MAX_WAIT(MW32)) u_dut32 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus32));
  rv_lsu #(.XLEN(64), .MAX_WAIT(15))   u_dut64 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus64));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model32 = '0;
  logic [63:0] model64 = '0;

  // ready_at: WAIT cycle (1-based) that sees mem_ready; outside 1..MW32 means never
  task automatic access32(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                          input int ready_at, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    int          term;
    logic        to;
    logic [63:0] got;
    to   = !(ready_at >= 1 && ready_at <= MW32);
    term = to ? MW32 : ready_at;
    if (to) model32 = '0;
    else if (!we) model32 = exp_rdata;
    @(posedge CLK); #1;
    bus32.MemRead = !we; bus32.MemWrite = we;
    bus32.funct3 = f3; bus32.addr = a; bus32.wdata = wd;
    #1;
    n_checks++; if (bus32.stall !== 1'b1) begin n_fail++; $display("FAIL %s c0_stall: got %b expected 1", name, bus32.stall); end
    n_checks++; if (bus32.mem_req !== 1'b0) begin n_fail++; $display("FAIL %s c0_mem_req: got %b expected 0", name, bus32.mem_req); end
    n_checks++; if (bus32.misaligned !== 1'b0) begin n_fail++; $display("FAIL %s c0_misaligned: got %b expected 0", name, bus32.misaligned); end
    sb_q.push_back({32'b0, model32});
    @(posedge CLK); #1;
    bus32.MemRead = 1'b0; bus32.MemWrite = 1'b0;
    for (int k = 1; k <= term; k++) begin
      if (k == ready_at) begin bus32.mem_ready = 1'b1; bus32.mem_rdata = mrd; end
      #1;
      n_checks++; if (bus32.stall !== 1'b1) begin n_fail++; $display("FAIL %s wait%0d_stall: got %b expected 1", name, k, bus32.stall); end
      n_checks++; if (bus32.mem_req !== 1'b1) begin n_fail++; $display("FAIL %s wait%0d_mem_req: got %b expected 1", name, k, bus32.mem_req); end
      n_checks++; if (bus32.timeout !== (to && k == term)) begin n_fail++; $display("FAIL %s wait%0d_timeout: got %b expected %b", name, k, bus32.timeout, (to && k == term)); end
      n_checks++; if (bus32.mem_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL %s mem_addr: got %h expected %h", name, bus32.mem_addr, {a[31:2], 2'b00}); end
      n_checks++; if (bus32.mem_be !== exp_be) begin n_fail++; $display("FAIL %s mem_be: got %h expected %h", name, bus32.mem_be, exp_be); end
      n_checks++; if (bus32.mem_we !== we) begin n_fail++; $display("FAIL %s mem_we: got %b expected %b", name, bus32.mem_we, we); end
      if (we) begin
        n_checks++; if (bus32.mem_wdata !== exp_wdata) begin n_fail++; $display("FAIL %s mem_wdata: got %h expected %h", name, bus32.mem_wdata, exp_wdata); end
      end
      @(posedge CLK); #1;
      bus32.mem_ready = 1'b0; bus32.mem_rdata = '0;
    end
    #1;
    n_checks++; if (bus32.stall !== 1'b0) begin n_fail++; $display("FAIL %s done_stall: got %b expected 0", name, bus32.stall); end
    n_checks++; if (bus32.mem_req !== 1'b0) begin n_fail++; $display("FAIL %s done_mem_req: got %b expected 0", name, bus32.mem_req); end
    n_checks++; if (bus32.timeout !== 1'b0) begin n_fail++; $display("FAIL %s done_timeout: got %b expected 0", name, bus32.timeout); end
    n_checks++;
    if (sb_q.size() == 0) begin n_fail++; $display("FAIL %s scoreboard: got empty queue expected one entry", name); end
    else begin
      got = sb_q.pop_front();
      if (bus32.rdata !== got[31:0]) begin n_fail++; $display("FAIL %s rdata: got %h expected %h", name, bus32.rdata, got[31:0]); end
    end
  endtask

  task automatic access64(input string name, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] mrd, input logic [7:0] exp_be, input logic [63:0] exp_rdata);
    logic [63:0] got;
    model64 = exp_rdata;
    @(posedge CLK); #1;
    bus64.MemRead = 1'b1; bus64.MemWrite = 1'b0; bus64.funct3 = f3; bus64.addr = a;
    #1;
    n_checks++; if (bus64.stall !== 1'b1) begin n_fail++; $display("FAIL %s c0_stall: got %b expected 1", name, bus64.stall); end
    sb_q.push_back(model64);
    @(posedge CLK); #1;
    bus64.MemRead = 1'b0; bus64.mem_ready = 1'b1; bus64.mem_rdata = mrd;
    #1;
    n_checks++; if (bus64.mem_req !== 1'b1) begin n_fail++; $display("FAIL %s mem_req: got %b expected 1", name, bus64.mem_req); end
    n_checks++; if (bus64.mem_be !== exp_be) begin n_fail++; $display("FAIL %s mem_be: got %h expected %h", name, bus64.mem_be, exp_be); end
    n_checks++; if (bus64.mem_addr !== {a[63:3], 3'b000}) begin n_fail++; $display("FAIL %s mem_addr: got %h expected %h", name, bus64.mem_addr, {a[63:3], 3'b000}); end
    @(posedge CLK); #1;
    bus64.mem_ready = 1'b0; bus64.mem_rdata = '0;
    #1;
    n_checks++; if (bus64.stall !== 1'b0) begin n_fail++; $display("FAIL %s done_stall: got %b expected 0", name, bus64.stall); end
    n_checks++;
    if (sb_q.size() == 0) begin n_fail++; $display("FAIL %s scoreboard: got empty queue expected one entry", name); end
    else begin
      got = sb_q.pop_front();
      if (bus64.rdata !== got) begin n_fail++; $display("FAIL %s rdata: got %h expected %h", name, bus64.rdata, got); end
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (bus32.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus32.stall); end
    n_checks++; if (bus32.mem_req !== 1'b0 || bus32.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req_we: got %b%b expected 00", bus32.mem_req, bus32.mem_we); end
    n_checks++; if (bus32.misaligned !== 1'b0 || bus32.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b expected 00", bus32.misaligned, bus32.timeout); end
    n_checks++; if (bus32.mem_addr !== 32'h0 || bus32.mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_addr_be: got %h/%h expected 0/0", bus32.mem_addr, bus32.mem_be); end
    n_checks++; if (bus32.mem_wdata !== 32'h0 || bus32.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", bus32.mem_wdata, bus32.rdata); end
    n_checks++; if (bus64.mem_req !== 1'b0 || bus64.rdata !== 64'h0) begin n_fail++; $display("FAIL reset_64: got %b/%h expected 0/0", bus64.mem_req, bus64.rdata); end
    @(negedge CLK); RESET_N = 1'b1;
  endtask

  task automatic test_loads();
    access32("lw",  1'b0, F3_W,  32'h100, '0, 32'hDEADBEEF, 1, 4'hF, '0, 32'hDEADBEEF);
    access32("lb",  1'b0, F3_B,  32'h103, '0, 32'h80FF0000, 1, 4'h8, '0, 32'hFFFFFF80);
    access32("lbu", 1'b0, F3_BU, 32'h103, '0, 32'h80FF0000, 1, 4'h8, '0, 32'h00000080);
    access32("lh",  1'b0, F3_H,  32'h106, '0, 32'hABCD1234, 2, 4'hC, '0, 32'hFFFFABCD);
    access32("lhu", 1'b0, F3_HU, 32'h106, '0, 32'hABCD1234, 2, 4'hC, '0, 32'h0000ABCD);
  endtask

  task automatic test_stores();
    access32("sh", 1'b1, F3_H, 32'h202, 32'h00001234, '0, 1, 4'hC, 32'h12340000, 32'h0);
    access32("sb", 1'b1, F3_B, 32'h201, 32'h000000A5, '0, 2, 4'h2, 32'h0000A500, 32'h0);
    access32("sw", 1'b1, F3_W, 32'h204, 32'hCAFEBABE, '0, 1, 4'hF, 32'hCAFEBABE, 32'h0);
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s[5] = '{F3_W, F3_H, F3_D, F3_WU, F3_W};
    logic [31:0] as[5]  = '{32'h101, 32'h103, 32'h100, 32'h100, 32'h102};
    logic        wes[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      bus32.MemRead = !wes[i]; bus32.MemWrite = wes[i]; bus32.funct3 = f3s[i]; bus32.addr = as[i];
      #1;
      n_checks++; if (bus32.misaligned !== 1'b1) begin n_fail++; $display("FAIL mis%0d_pulse: got %b expected 1", i, bus32.misaligned); end
      n_checks++; if (bus32.stall !== 1'b0) begin n_fail++; $display("FAIL mis%0d_stall: got %b expected 0", i, bus32.stall); end
      @(posedge CLK); #1;
      bus32.MemRead = 1'b0; bus32.MemWrite = 1'b0;
      #1;
      n_checks++; if (bus32.misaligned !== 1'b0) begin n_fail++; $display("FAIL mis%0d_one_cycle: got %b expected 0", i, bus32.misaligned); end
      n_checks++; if (bus32.mem_req !== 1'b0) begin n_fail++; $display("FAIL mis%0d_mem_req: got %b expected 0", i, bus32.mem_req); end
    end
  endtask

  task automatic test_timeout();
    access32("lw_timeout", 1'b0, F3_W, 32'h300, '0, '0, 0, 4'hF, '0, 32'h0);
    access32("lw_tie",     1'b0, F3_W, 32'h304, '0, 32'hCAFEF00D, MW32, 4'hF, '0, 32'hCAFEF00D);
    access32("sb_timeout", 1'b1, F3_B, 32'h308, 32'h11, '0, 0, 4'h1, 32'h11, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    @(posedge CLK); #1;
    bus32.MemRead = 1'b1; bus32.funct3 = F3_W; bus32.addr = 32'h400;
    @(posedge CLK); #1;
    bus32.MemRead = 1'b0;
    #1;
    n_checks++; if (bus32.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_req: got %b expected 1", bus32.mem_req); end
    #1; RESET_N = 1'b0;
    #1;
    n_checks++; if (bus32.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 0", bus32.mem_req); end
    n_checks++; if (bus32.stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", bus32.stall); end
    n_checks++; if (bus32.timeout !== 1'b0) begin n_fail++; $display("FAIL rst_mid_timeout: got %b expected 0", bus32.timeout); end
    n_checks++; if (bus32.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected 0", bus32.rdata); end
    model32 = '0;
    @(negedge CLK); RESET_N = 1'b1;
    access32("lw_after_rst", 1'b0, F3_W, 32'h104, '0, 32'h11223344, 2, 4'hF, '0, 32'h11223344);
  endtask

  task automatic test_xlen64();
    access64("ld64",  F3_D,  64'h8, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF);
    access64("lw64",  F3_W,  64'hC, 64'h80000000_00000000, 8'hF0, 64'hFFFFFFFF_80000000);
    access64("lwu64", F3_WU, 64'hC, 64'h80000000_00000000, 8'hF0, 64'h00000000_80000000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N = 1'b0;
    bus32.MemRead = 1'b0; bus32.MemWrite = 1'b0; bus32.funct3 = '0; bus32.addr = '0;
    bus32.wdata = '0; bus32.mem_ready = 1'b0; bus32.mem_rdata = '0;
    bus64.MemRead = 1'b0; bus64.MemWrite = 1'b0; bus64.funct3 = '0; bus64.addr = '0;
    bus64.wdata = '0; bus64.mem_ready = 1'b0; bus64.mem_rdata = '0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_xlen64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_lsu.md
# rv_lsu

Parametrised load/store unit between the core's MEM stage and a wait-stated data memory. It replaces the direct single-cycle DMEM connection (`daddr`/`ddata_w`/`ddata_r`) with a request/ready handshake, byte-lane enables, sign/zero extension, misalignment detection and a bounded-wait timeout. While an access is outstanding it stalls the pipeline.

## Interface
Parameters:
- `XLEN`, default 32: data/address width; legal values 32 or 64. Byte lanes are `NB = XLEN/8`; offset bits are `OB = log2(NB)`.
- `MAX_WAIT`, default 15: the maximum number of WAIT cycles before a timeout; must be ≥ 1.

Ports (clock and reset first):
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  load request from the MEM stage.
- `MemWrite`  in  1  store request from the MEM stage; never asserted together with `MemRead`.
- `funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
- `addr`  in  XLEN  byte address of the access.
- `wdata`  in  XLEN  store data, right-aligned.
- `stall`  out  1  holds the pipeline; combinational.
- `rdata`  out  XLEN  extended load result.
- `misaligned`  out  1  one-cycle misalignment fault pulse.
- `timeout`  out  1  one-cycle timeout pulse.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  XLEN  lane-aligned address: `addr` with the low OB bits zeroed.
- `mem_be`  out  NB  byte enables.
- `mem_wdata`  out  XLEN  store data shifted into the addressed lanes.
- `mem_ready`  in  1  memory completion; read data is valid in the same cycle.
- `mem_rdata`  in  XLEN  full-width read data.

## Operation
The unit has three states: IDLE, WAIT and DONE.

**IDLE**
- When `MemRead|MemWrite` is asserted and the access is aligned:
  - `stall` = 1.
  - Register `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, the funct3 and the byte offset.
  - Go to WAIT.
- When the access is misaligned:
  - `misaligned` = 1 for this cycle only.
  - `stall` = 0.
  - No memory request is made.
  - Stay in IDLE.
- Alignment rules:
  - H/HU require `addr[0]` = 0.
  - W/WU require `addr[1:0]` = 0.
  - D requires `addr[2:0]` = 0.
  - B is always aligned.
  - A D or WU encoding at XLEN=32 is treated as misaligned.

**WAIT**
- `mem_req` = 1 and `stall` = 1.
- The wait counter increments every cycle.
- On `mem_ready` = 1:
  - For a load, extract the addressed lanes from `mem_rdata`, then sign- or zero-extend per funct3.
  - Register the result into `rdata`.
  - Go to DONE.
- When the counter reaches `MAX_WAIT` without `mem_ready`:
  - `timeout` = 1 for one cycle.
  - `rdata` = 0.
  - Go to DONE.
- If `mem_ready` arrives in the same cycle the counter reaches `MAX_WAIT`, `mem_ready` wins and no timeout is signalled.

**DONE**
- `stall` = 0, so the pipeline advances at this edge.
- `mem_req` = 0.
- `rdata` holds its value.
- Go to IDLE unconditionally; a request present during DONE is ignored.

**Stores**
- `mem_be` is one-hot for B, a 2-bit mask for H and a 4-bit mask for W, shifted left by the byte offset; all ones for D.
- `mem_wdata` = `wdata` shifted left by 8×offset.
- `rdata` is unchanged after a store.

## Timing
Reset values, applied immediately while `RESET_N` = 0:
- State IDLE; wait counter 0.
- `mem_req`, `mem_we`, `misaligned`, `timeout` = 0.
- `mem_addr`, `mem_be`, `mem_wdata`, `rdata` = 0.
- `stall` = 0.

Cycle-level behaviour:
- Reset asserted mid-access drops `mem_req` asynchronously; the access is abandoned with no pulse.
- Minimum access latency: request seen in cycle c0, `mem_ready` in c1, DONE in c2.
  - `stall` is high in c0 and c1 and low in c2.
  - `rdata` is valid from c2.
- `mem_req` is registered. Its first high cycle is c0+1, and it stays high until the cycle of `mem_ready` or timeout.
- `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` are stable for the whole time `mem_req` is high.
- Worst-case latency is `MAX_WAIT`+2 cycles.

## Structure
- Package `rv_lsu_pkg` holds:
  - funct3 localparams: `F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`.
  - The state enum `lsu_state_t` {IDLE, WAIT, DONE}.
- One sub-module, `rv_lsu_align`. It is purely combinational and parametrised by XLEN:
  - alignment check;
  - byte-enable and store-data shift;
  - load lane extraction and extension.
- `rv_lsu` holds the FSM, the counter and the registers.

## Test plan
- **LW, ready in one cycle.** Stimulus: XLEN=32, `MemRead`, funct3 010, addr 0x100; `mem_ready` in c1 with `mem_rdata` 0xDEADBEEF. Required: `mem_be` 0xF, `mem_addr` 0x100, `stall` 1,1,0, `rdata` 0xDEADBEEF in c2.
- **LB and LBU.** Stimulus: addr 0x103, `mem_rdata` 0x80FF_0000. Required: LB gives `rdata` 0xFFFFFF80 and `mem_be` 0x8; LBU gives 0x00000080.
- **SH.** Stimulus: addr 0x202, `wdata` 0x0000_1234. Required: `mem_we` 1, `mem_be` 0xC, `mem_wdata` 0x1234_0000, `mem_addr` 0x200.
- **Misaligned LW.** Stimulus: addr 0x101. Required: `misaligned` pulses for 1 cycle, `mem_req` never rises, `stall` stays 0.
- **Timeout and the ready/timeout tie.** Stimulus: `MAX_WAIT`=3 and `mem_ready` held low. Required: `timeout` pulses on the 3rd WAIT cycle, `rdata` 0, `stall` drops the next cycle. Repeat with `mem_ready` on the 3rd cycle: no timeout, data captured.
- **Reset mid-WAIT and XLEN=64.**
  - Assert `RESET_N`=0 in WAIT: `mem_req` and `stall` go 0 immediately, and the next request starts cleanly.
  - At XLEN=64, LD from addr 0x8 returns the full 64-bit word with `mem_be` 0xFF.
